// File: rtl/uart_trx.sv
// uart_trx: full-duplex UART transceiver with TX handshake and held RX word.
// Optional loopback port is enabled by defining UART_TRX_LOOPBACK_EN.
module uart_trx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
`ifdef UART_TRX_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              pe,
  output logic              fe,
  output logic              oe,
  output logic              rx_busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] BAUD_END = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_END = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic [CW-1:0] LAST_STP = CW'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY != 0);
  localparam bit ODD     = (PARITY == 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BRK
  } rx_state_e;

  tx_state_e tx_state_q, tx_state_d;
  logic [BW-1:0] tx_cnt_q, tx_cnt_d;
  logic [CW-1:0] tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic tx_par_q, tx_par_d;
  logic txd_q, txd_d;

  rx_state_e rx_state_q, rx_state_d;
  logic [BW-1:0] rx_cnt_q, rx_cnt_d;
  logic [CW-1:0] rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic rx_perr_q, rx_perr_d;
  logic [1:0] sync_q, sync_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d;
  logic pe_q, pe_d;
  logic fe_q, fe_d;
  logic oe_q, oe_d;

  logic rx_src;
  logic rx_in;
  logic tx_end;
  logic rx_end;
  logic commit;

`ifdef UART_TRX_LOOPBACK_EN
  assign txd    = loopback ? 1'b1 : txd_q;
  assign rx_src = loopback ? txd_q : rxd;
`else
  assign txd    = txd_q;
  assign rx_src = rxd;
`endif

  assign rx_in    = sync_q[1];
  assign tx_ready = (tx_state_q == TX_IDLE);
  assign rx_busy  = (rx_state_q != RX_IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign pe       = pe_q;
  assign fe       = fe_q;
  assign oe       = oe_q;

  // TX framing: load on accept, then walk start/data/parity/stop bits
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    txd_d      = txd_q;
    tx_end     = (tx_cnt_q == BAUD_END);
    if (tx_state_q != TX_IDLE)
      tx_cnt_d = tx_end ? '0 : tx_cnt_q + 1'b1;
    unique case (tx_state_q)
      TX_IDLE: if (tx_valid) begin
        tx_sh_d    = tx_data;
        tx_par_d   = ^tx_data ^ ODD;
        txd_d      = 1'b0;
        tx_cnt_d   = '0;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_end) begin
        txd_d      = tx_sh_q[0];
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_end) begin
        if (tx_bit_q == LAST_BIT) begin
          tx_bit_d   = '0;
          tx_state_d = HAS_PAR ? TX_PAR : TX_STOP;
          txd_d      = HAS_PAR ? tx_par_q : 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
          tx_sh_d  = tx_sh_q >> 1;
          txd_d    = tx_sh_q[1];
        end
      end
      TX_PAR: if (tx_end) begin
        txd_d      = 1'b1;
        tx_bit_d   = '0;
        tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_end) begin
        if (tx_bit_q == LAST_STP) tx_state_d = TX_IDLE;
        else tx_bit_d = tx_bit_q + 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX framing, commit into the held word register, ack and overrun
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_perr_d  = rx_perr_q;
    sync_d     = {sync_q[0], rx_src};
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    pe_d       = pe_q;
    fe_d       = fe_q;
    oe_d       = oe_q;
    commit     = 1'b0;
    rx_end     = (rx_cnt_q == BAUD_END);
    if (rx_state_q != RX_IDLE && rx_state_q != RX_BRK)
      rx_cnt_d = rx_end ? '0 : rx_cnt_q + 1'b1;
    unique case (rx_state_q)
      RX_IDLE: if (!rx_in) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_in ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_end) begin
        rx_sh_d = {rx_in, rx_sh_q[DATA_W-1:1]};
        if (rx_bit_q == LAST_BIT) begin
          rx_bit_d   = '0;
          rx_perr_d  = 1'b0;
          rx_state_d = HAS_PAR ? RX_PAR : RX_STOP;
        end else begin
          rx_bit_d = rx_bit_q + 1'b1;
        end
      end
      RX_PAR: if (rx_end) begin
        rx_perr_d  = ((^rx_sh_q) ^ ODD) != rx_in;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_end) begin
        commit     = 1'b1;
        rx_state_d = rx_in ? RX_IDLE : RX_BRK;
      end
      RX_BRK: if (rx_in) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
    if (commit) begin
      if (!rx_valid_q || rx_ack) begin
        rx_data_d  = rx_sh_q;
        pe_d       = rx_perr_q;
        fe_d       = !rx_in;
        rx_valid_d = 1'b1;
      end else begin
        oe_d = 1'b1;
      end
    end else if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
      oe_d       = 1'b0;
    end
  end

  // State registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_perr_q  <= 1'b0;
      sync_q     <= 2'b11;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_perr_q  <= rx_perr_d;
      sync_q     <= sync_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      oe_q       <= oe_d;
    end
  end

endmodule

// File: tb/tb_uart_trx.sv
// tb_uart_trx: directed and randomized checks of uart_trx
// with 8 data bits, 16 clocks per bit, even parity, one stop bit.
module tb_uart_trx;

  localparam int DW  = 8;
  localparam int CPB = 16;
  localparam int NB  = 11;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready;
  logic txd;
  logic rxd;
  logic rxd_drv = 1'b1;
  logic loop = 1'b0;
  logic [DW-1:0] rx_data;
  logic rx_valid;
  logic rx_ack = 1'b0;
  logic pe, fe, oe, rx_busy;

  int errors = 0;
  int checks = 0;
  int vrise = 0;
  logic vprev = 1'b0;

  assign rxd = loop ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_trx #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB),
    .PARITY(2), .STOP_BITS(1)
  ) dut (
    .clk(clk), .clr(clr),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd),
    .rxd(rxd), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ack(rx_ack),
    .pe(pe), .fe(fe), .oe(oe), .rx_busy(rx_busy)
  );

  always @(negedge clk) begin
    if (rx_valid && !vprev) vrise++;
    vprev = rx_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start, data LSB first, even parity, stop
  function automatic logic [NB-1:0] frame_of(input logic [DW-1:0] d);
    logic [NB-1:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = d[i];
    f[DW+1] = ^d;
    f[DW+2] = 1'b1;
    return f;
  endfunction

  task automatic drive_bit(input logic b);
    rxd_drv = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pb,
                            input logic sb);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit(pb);
    drive_bit(sb);
  endtask

  task automatic wait_rx(input int lim, output bit got);
    got = 0;
    for (int i = 0; i < lim && !got; i++) begin
      if (rx_valid) got = 1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_tx_idle(input int lim, output bit got);
    got = 0;
    for (int i = 0; i < lim && !got; i++) begin
      if (tx_ready) got = 1;
      else @(negedge clk);
    end
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic tx_loop(input logic [DW-1:0] d);
    bit got;
    int v0;
    loop = 1'b1;
    v0 = vrise;
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = DW'($urandom);
    wait_rx(300, got);
    check("lb_rx_seen", 32'(got), 1);
    check("lb_data", 32'(rx_data), 32'(d));
    check("lb_pe", 32'(pe), 0);
    check("lb_fe", 32'(fe), 0);
    check("lb_oe", 32'(oe), 0);
    wait_tx_idle(100, got);
    check("lb_tx_idle", 32'(got), 1);
    check("lb_one_pulse", 32'(vrise - v0), 1);
    do_ack();
    check("lb_ack_clears", 32'(rx_valid), 0);
    loop = 1'b0;
  endtask

  initial begin
    logic [NB-1:0] f;
    logic [DW-1:0] d;
    logic pb;
    int bad, low, busy, v0;
    bit got, seen;

    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 1);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_flags", {29'd0, pe, fe, oe}, 0);
    check("rst_rx_busy", 32'(rx_busy), 0);
    clr = 1'b0;
    @(negedge clk);

    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = 8'h00;
    f = frame_of(8'hA5);
    bad = 0;
    low = 0;
    for (int k = 0; k < NB * CPB; k++) begin
      if (txd !== f[k / CPB]) bad++;
      if (k % CPB == CPB / 2)
        check($sformatf("tx_bit%0d", k / CPB), 32'(txd), 32'(f[k / CPB]));
      if (!tx_ready) low++;
      @(negedge clk);
    end
    check("tx_ready_back", 32'(tx_ready), 1);
    check("tx_ready_low_cycles", 32'(low), NB * CPB);
    check("tx_txd_all_cycles", 32'(bad), 0);
    check("tx_idle_high", 32'(txd), 1);

    tx_loop(8'h3C);
    for (int n = 0; n < 3; n++) tx_loop(DW'($urandom));

    send_frame(8'h01, 1'b0, 1'b1);
    wait_rx(10, got);
    check("pe_rx_seen", 32'(got), 1);
    check("pe_data", 32'(rx_data), 32'h01);
    check("pe_pe", 32'(pe), 32'((^8'h01) != 1'b0));
    check("pe_fe", 32'(fe), 0);
    do_ack();

    for (int n = 0; n < 3; n++) begin
      d = DW'($urandom);
      pb = 1'($urandom);
      send_frame(d, pb, 1'b1);
      wait_rx(10, got);
      check("rnd_rx_seen", 32'(got), 1);
      check("rnd_data", 32'(rx_data), 32'(d));
      check("rnd_pe", 32'(pe), 32'((^d) != pb));
      check("rnd_fe", 32'(fe), 0);
      do_ack();
    end

    v0 = vrise;
    send_frame(8'h55, ^8'h55, 1'b0);
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (rx_busy) busy++;
      @(negedge clk);
    end
    check("brk_busy_held", 32'(busy), 40);
    check("brk_fe", 32'(fe), 1);
    check("brk_data", 32'(rx_data), 32'h55);
    check("brk_valid", 32'(rx_valid), 1);
    rxd_drv = 1'b1;
    repeat (6) @(negedge clk);
    check("brk_idle", 32'(rx_busy), 0);
    do_ack();
    repeat (20) @(negedge clk);
    check("brk_one_commit", 32'(vrise - v0), 1);
    check("brk_no_second", 32'(rx_valid), 0);

    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    check("ovr_valid", 32'(rx_valid), 1);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_oe", 32'(oe), 1);
    check("ovr_fe", 32'(fe), 0);
    do_ack();
    check("ovr_ack_valid", 32'(rx_valid), 0);
    check("ovr_ack_oe", 32'(oe), 0);

    v0 = vrise;
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (rx_busy) seen = 1;
      @(negedge clk);
    end
    check("glitch_busy_seen", 32'(seen), 1);
    check("glitch_busy_back", 32'(rx_busy), 0);
    check("glitch_no_commit", 32'(vrise - v0), 0);

    tx_data = DW'($urandom);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (50) @(negedge clk);
    check("midtx_busy", 32'(tx_ready), 0);
    clr = 1'b1;
    @(negedge clk);
    check("clr_txd", 32'(txd), 1);
    check("clr_tx_ready", 32'(tx_ready), 1);
    check("clr_rx_valid", 32'(rx_valid), 0);
    clr = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
